// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares one single-port 32-bit frame/pattern RAM between two requesters.
//   Port A (scan-out fetch) has priority. Port B (host writer) is granted after
//   at most B_MAX_WAIT consecutive denials. At most one RAM access is issued
//   per clock. Read data returns to the issuing port two cycles after its grant.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   a_req_i .. a_wdata_i     port A command (held until a_gnt_o)
//   a_gnt_o                  pulse: A command issued onto the RAM pins
//   a_rvalid_o, a_rdata_o    A read return
//   b_*                      same set for port B
//   ram_wr_en_o, ram_addr_o, ram_data_in_o   registered RAM command
//   ram_mem_out_i            RAM read data (one-cycle latency, 0 on writes)
//
// Priority FSM (state is decoded from the B wait counter)
//   state        | meaning
//   PRIO_NORMAL  | A wins when both ports request
//   PRIO_FORCE_B | B has waited B_MAX_WAIT edges, B wins this edge
module vram_port_arbiter #(
   parameter int RAM_ADDR_BITS = 10,
   parameter int B_MAX_WAIT    = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     a_req_i,
   input  logic                     a_we_i,
   input  logic [RAM_ADDR_BITS-1:0] a_addr_i,
   input  logic [31:0]              a_wdata_i,
   output logic                     a_gnt_o,
   output logic                     a_rvalid_o,
   output logic [31:0]              a_rdata_o,
   input  logic                     b_req_i,
   input  logic                     b_we_i,
   input  logic [RAM_ADDR_BITS-1:0] b_addr_i,
   input  logic [31:0]              b_wdata_i,
   output logic                     b_gnt_o,
   output logic                     b_rvalid_o,
   output logic [31:0]              b_rdata_o,
   output logic                     ram_wr_en_o,
   output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
   output logic [31:0]              ram_data_in_o,
   input  logic [31:0]              ram_mem_out_i
);

   typedef enum logic {PRIO_NORMAL, PRIO_FORCE_B} prio_e;

   typedef struct packed {
      logic valid;
      logic owner;    // 0 = port A, 1 = port B
      logic is_read;
   } tag_t;

   localparam logic [3:0] WAIT_MAX = 4'(B_MAX_WAIT);

   prio_e                     prio_state;
   logic [3:0]                b_wait_q, b_wait_d;
   logic                      grant_a, grant_b, grant_any;
   logic                      sel_we;
   logic [RAM_ADDR_BITS-1:0]  sel_addr;
   logic [31:0]               sel_wdata;
   tag_t                      tag_s1_q, tag_s1_d, tag_s2_q;

   logic                      a_gnt_q, b_gnt_q;
   logic                      a_rvalid_q, b_rvalid_q;
   logic [31:0]               a_rdata_q, b_rdata_q;
   logic                      ram_wr_en_q;
   logic [RAM_ADDR_BITS-1:0]  ram_addr_q;
   logic [31:0]               ram_data_q;

   always_comb begin
      prio_state = (b_wait_q == WAIT_MAX) ? PRIO_FORCE_B : PRIO_NORMAL;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      b_wait_d   = 4'd0;

      case (prio_state)
         PRIO_FORCE_B: begin
            grant_b = b_req_i;
            grant_a = a_req_i & ~b_req_i;
         end
         default: begin
            grant_a = a_req_i;
            grant_b = b_req_i & ~a_req_i;
         end
      endcase

      // Counter tracks consecutive denials; saturates rather than wrapping.
      if (b_req_i && !grant_b) begin
         b_wait_d = (b_wait_q == WAIT_MAX) ? b_wait_q : b_wait_q + 4'd1;
      end
   end

   always_comb begin
      grant_any = grant_a | grant_b;
      sel_we    = grant_b ? b_we_i    : a_we_i;
      sel_addr  = grant_b ? b_addr_i  : a_addr_i;
      sel_wdata = grant_b ? b_wdata_i : a_wdata_i;
      tag_s1_d  = '{valid: grant_any, owner: grant_b, is_read: ~sel_we};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_wait_q    <= 4'd0;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         ram_wr_en_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= 32'd0;
         tag_s1_q    <= '0;
         tag_s2_q    <= '0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         a_rdata_q   <= 32'd0;
         b_rdata_q   <= 32'd0;
      end else begin
         b_wait_q    <= b_wait_d;
         a_gnt_q     <= grant_a;
         b_gnt_q     <= grant_b;
         ram_wr_en_q <= grant_any & sel_we;
         // Address and data hold on idle edges so the RAM pins stay quiet.
         if (grant_any) begin
            ram_addr_q <= sel_addr;
            ram_data_q <= sel_wdata;
         end
         // Stage 1: command on RAM pins. Stage 2: RAM output valid.
         tag_s1_q   <= tag_s1_d;
         tag_s2_q   <= tag_s1_q;
         a_rvalid_q <= tag_s2_q.valid & tag_s2_q.is_read & ~tag_s2_q.owner;
         b_rvalid_q <= tag_s2_q.valid & tag_s2_q.is_read &  tag_s2_q.owner;
         if (tag_s2_q.valid && tag_s2_q.is_read && !tag_s2_q.owner) begin
            a_rdata_q <= ram_mem_out_i;
         end
         if (tag_s2_q.valid && tag_s2_q.is_read && tag_s2_q.owner) begin
            b_rdata_q <= ram_mem_out_i;
         end
      end
   end

   assign a_gnt_o       = a_gnt_q;
   assign b_gnt_o       = b_gnt_q;
   assign a_rvalid_o    = a_rvalid_q;
   assign b_rvalid_o    = b_rvalid_q;
   assign a_rdata_o     = a_rdata_q;
   assign b_rdata_o     = b_rdata_q;
   assign ram_wr_en_o   = ram_wr_en_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_data_in_o = ram_data_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter
//   Directed bench for vram_port_arbiter with a behavioural single-port RAM
//   (synchronous read, registered output, zero on write cycles).
module tb_vram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [9:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        ram_wr_en;
   logic [9:0]  ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_out = 32'd0;
   logic [31:0] mem [0:1023];

   int n_checks = 0;
   int n_pass   = 0;
   int a_rv_cnt = 0;
   int b_rv_cnt = 0;
   bit rv_both  = 1'b0;

   always #5 clk = ~clk;

   vram_port_arbiter #(.RAM_ADDR_BITS(10), .B_MAX_WAIT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
      .ram_wr_en_o(ram_wr_en), .ram_addr_o(ram_addr), .ram_data_in_o(ram_data_in),
      .ram_mem_out_i(ram_out)
   );

   always @(posedge clk) begin
      if (ram_wr_en) begin
         mem[ram_addr] <= ram_data_in;
         ram_out       <= 32'd0;
      end else begin
         ram_out <= mem[ram_addr];
      end
   end

   always @(negedge clk) begin
      if (a_rvalid && b_rvalid) rv_both = 1'b1;
      if (a_rvalid) a_rv_cnt++;
      if (b_rvalid) b_rv_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic b_write(input logic [9:0] addr, input logic [31:0] data);
      int n = 0;
      b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = data;
      do begin
         step();
         n++;
      end while (!b_gnt && n < 20);
      check("preload_gnt", b_gnt, 1);
      b_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int issued, rcv, first, last, rv_before;

      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000; a_wdata = 32'd0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 10'h001; b_wdata = 32'd0;

      // Reset held two cycles with both ports requesting
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_a_gnt", a_gnt, 0);
         check("rst_b_gnt", b_gnt, 0);
         check("rst_wr_en", ram_wr_en, 0);
         check("rst_addr", ram_addr, 0);
         check("rst_din", ram_data_in, 0);
         check("rst_rv", {a_rvalid, b_rvalid}, 0);
         check("rst_a_rdata", a_rdata, 0);
         check("rst_b_rdata", b_rdata, 0);
      end
      rst = 1'b0;
      step();
      check("post_rst_a_gnt", a_gnt, 1);
      check("post_rst_b_gnt", b_gnt, 0);
      a_req = 1'b0; b_req = 1'b0;
      idle(4);

      // Preload through port B
      for (int i = 0; i < 8; i++) b_write(10'(i), 32'h100 + 32'(i));
      b_write(10'h010, 32'h11);
      idle(3);

      // Back-to-back A reads 0x000..0x007
      issued = 0; rcv = 0; first = -1; last = -1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h000;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (a_gnt) begin
            issued++;
            if (issued < 8) a_addr = 10'(issued);
            else a_req = 1'b0;
         end
         if (a_rvalid) begin
            check($sformatf("stream_d%0d", rcv), a_rdata, 32'h100 + 32'(rcv));
            if (first < 0) first = c;
            last = c;
            rcv++;
         end
      end
      check("stream_gnts", issued, 8);
      check("stream_rvalids", rcv, 8);
      check("stream_span", last - first, 7);
      check("stream_first_lat", first, 3);

      // B write then immediate read of the same address
      rv_before = a_rv_cnt;
      b_req = 1'b1; b_we = 1'b1; b_addr = 10'h005; b_wdata = 32'hDEADBEEF;
      step();
      check("bw_gnt", b_gnt, 1);
      check("bw_wr_en", ram_wr_en, 1);
      check("bw_addr", ram_addr, 10'h005);
      check("bw_din", ram_data_in, 32'hDEADBEEF);
      b_we = 1'b0;
      step();
      check("br_gnt", b_gnt, 1);
      check("br_wr_en", ram_wr_en, 0);
      b_req = 1'b0;
      step();
      check("br_rv_early", b_rvalid, 0);
      step();
      check("br_rvalid", b_rvalid, 1);
      check("br_rdata", b_rdata, 32'hDEADBEEF);
      idle(2);
      check("br_no_a_rv", a_rv_cnt - rv_before, 0);

      // Priority: A held continuously, B granted after 4 denials
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h001;
      b_req = 1'b1; b_we = 1'b0; b_addr = 10'h002;
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("prio_a_gnt%0d", i), {a_gnt, b_gnt}, 2'b10);
      end
      step();
      check("prio_b_gnt5", {a_gnt, b_gnt}, 2'b01);
      b_req = 1'b0;
      step();
      check("prio_a_resume", {a_gnt, b_gnt}, 2'b10);
      a_req = 1'b0;
      step();
      check("prio_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
      check("prio_b_rdata", b_rdata, 32'h102);
      step();
      check("prio_a_rvalid", {a_rvalid, b_rvalid}, 2'b10);
      check("prio_a_rdata", a_rdata, 32'h101);
      idle(3);

      // Simultaneous A read and B write to 0x010
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
      b_req = 1'b1; b_we = 1'b1; b_addr = 10'h010; b_wdata = 32'h22;
      step();
      check("wr_vs_rd_a_gnt", {a_gnt, b_gnt}, 2'b10);
      a_req = 1'b0;
      step();
      check("wr_vs_rd_b_gnt", {a_gnt, b_gnt}, 2'b01);
      check("wr_vs_rd_wr_en", ram_wr_en, 1);
      b_req = 1'b0;
      step();
      check("wr_vs_rd_rvalid", a_rvalid, 1);
      check("wr_vs_rd_old", a_rdata, 32'h11);
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h010;
      step();
      check("reread_gnt", a_gnt, 1);
      a_req = 1'b0;
      step();
      step();
      check("reread_rvalid", a_rvalid, 1);
      check("reread_new", a_rdata, 32'h22);
      idle(2);

      // Reset one cycle after a read grant
      rv_before = a_rv_cnt;
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h003;
      step();
      check("rst_mid_gnt", a_gnt, 1);
      a_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("rst_mid_rvalid", a_rvalid, 0);
      check("rst_mid_a_rdata", a_rdata, 0);
      check("rst_mid_b_rdata", b_rdata, 0);
      check("rst_mid_wr_en", ram_wr_en, 0);
      rst = 1'b0;
      idle(3);
      check("rst_mid_no_rv", a_rv_cnt - rv_before, 0);

      check("rvalid_exclusive", rv_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
